// File: rtl/line_follower_fsm_if.sv
// Line follower bus: run request and raw sensors in, steering code,
// wheel speed commands and line-lost flag out.
// master = controller/bench side, slave = line_follower_fsm side.
interface line_follower_fsm_if;
    logic       enable;
    logic [2:0] sensors;
    logic [1:0] follower_state;
    logic [7:0] Wheel_Speed_L;
    logic [7:0] Wheel_Speed_R;
    logic       line_lost;

    modport master (
        output enable,
        output sensors,
        input  follower_state,
        input  Wheel_Speed_L,
        input  Wheel_Speed_R,
        input  line_lost
    );

    modport slave (
        input  enable,
        input  sensors,
        output follower_state,
        output Wheel_Speed_L,
        output Wheel_Speed_R,
        output line_lost
    );
endinterface

// File: rtl/line_follower_fsm.sv
// line_follower_fsm: synchronises and debounces three IR line sensors {L,C,R},
// runs the steering state machine and produces the registered steering code
// plus ramped left/right wheel speed commands for the servo driver.
// Optional macro SEARCH_SWEEP_EN: while searching, alternate the steering
// direction every SWEEP_CYCLES (the SWEEP_CYCLES parameter exists only then).
module line_follower_fsm #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned LOST_TIMEOUT    = 50000000,
    parameter int unsigned RAMP_DIV        = 10000,
    parameter int unsigned SPEED_MAX       = 200,
    parameter int unsigned SPEED_TURN      = 80
`ifdef SEARCH_SWEEP_EN
    ,
    parameter int unsigned SWEEP_CYCLES    = 25000000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    line_follower_fsm_if.slave  bus
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LOST_W  = (LOST_TIMEOUT > 1)    ? $clog2(LOST_TIMEOUT)    : 1;
    localparam int RAMP_W  = (RAMP_DIV > 1)        ? $clog2(RAMP_DIV)        : 1;
`ifdef SEARCH_SWEEP_EN
    localparam int SWEEP_W = (SWEEP_CYCLES > 1)    ? $clog2(SWEEP_CYCLES)    : 1;
`endif

    localparam logic [7:0] SPD_MAX  = 8'(SPEED_MAX);
    localparam logic [7:0] SPD_TURN = 8'(SPEED_TURN);

    // last_dir encoding: 0 = LEFT (code 01), 1 = RIGHT (code 11)
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FORWARD,
        ST_TURN_LEFT,
        ST_TURN_RIGHT,
        ST_SEARCH,
        ST_STOPPED
    } state_t;

    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_filt;
    logic [DB_W-1:0]   r_db_cnt [3];

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_decoded;
    logic [1:0]        r_follower_state;
    logic [1:0]        w_follower_nxt;
    logic              r_last_dir;
    logic              w_last_dir_nxt;
    logic              w_search_dir;
    logic              r_line_lost;
    logic [LOST_W-1:0] r_lost_cnt;

    logic [RAMP_W-1:0] r_prescale;
    logic              w_tick;
    logic [7:0]        r_speed_l;
    logic [7:0]        r_speed_r;
    logic [7:0]        w_target_l;
    logic [7:0]        w_target_r;

`ifdef SEARCH_SWEEP_EN
    logic [SWEEP_W-1:0] r_sweep_cnt;
    logic               w_sweep_toggle;
`endif

    // Two-flop synchroniser on the raw asynchronous sensor inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= bus.sensors;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: a bit must disagree for DEBOUNCE_CYCLES straight cycles to flip
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_filt[i]   <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef SEARCH_SWEEP_EN
    // Sweep direction flips each time the sweep counter wraps while searching
    always_comb begin
        w_sweep_toggle = (r_state == ST_SEARCH) &&
                         (r_sweep_cnt == SWEEP_W'(SWEEP_CYCLES - 1));
        w_search_dir   = (r_state == ST_SEARCH) ? (r_last_dir ^ w_sweep_toggle)
                                                : r_last_dir;
    end

    // Sweep counter restarts on every SEARCH entry and wraps every SWEEP_CYCLES
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SEARCH)) begin
            r_sweep_cnt <= '0;
        end else if (w_sweep_toggle) begin
            r_sweep_cnt <= '0;
        end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
        end
    end
`else
    // Without sweeping, searching always steers toward the last turn taken
    always_comb begin
        w_search_dir = r_last_dir;
    end
`endif

    // Next-state logic: sensor-pattern decode, search timeout, enable override last
    always_comb begin
        w_decoded   = r_state;
        w_state_nxt = r_state;

        case (r_filt)
            3'b010, 3'b111: w_decoded = ST_FORWARD;
            3'b100, 3'b110: w_decoded = ST_TURN_LEFT;
            3'b001, 3'b011: w_decoded = ST_TURN_RIGHT;
            3'b101:         w_decoded = r_state;
            default:        w_decoded = ST_SEARCH;
        endcase

        case (r_state)
            ST_IDLE:       w_state_nxt = ST_FORWARD;
            ST_FORWARD,
            ST_TURN_LEFT,
            ST_TURN_RIGHT: w_state_nxt = w_decoded;
            ST_SEARCH: begin
                if ((r_filt == 3'b000) &&
                    (r_lost_cnt == LOST_W'(LOST_TIMEOUT - 1))) begin
                    w_state_nxt = ST_STOPPED;
                end else begin
                    w_state_nxt = w_decoded;
                end
            end
            ST_STOPPED:    w_state_nxt = ST_STOPPED;
            default:       w_state_nxt = ST_IDLE;
        endcase

        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Steering code and remembered direction, both derived from the next state
    always_comb begin
        w_follower_nxt = 2'b00;
        w_last_dir_nxt = r_last_dir;
        case (w_state_nxt)
            ST_TURN_LEFT: begin
                w_follower_nxt = 2'b01;
                w_last_dir_nxt = DIR_LEFT;
            end
            ST_TURN_RIGHT: begin
                w_follower_nxt = 2'b11;
                w_last_dir_nxt = DIR_RIGHT;
            end
            ST_SEARCH: begin
                w_follower_nxt = {w_search_dir, 1'b1};
                w_last_dir_nxt = w_search_dir;
            end
            default: begin
                w_follower_nxt = 2'b00;
            end
        endcase
    end

    // State register with the steering code and line-lost flag on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_follower_state <= 2'b00;
            r_last_dir       <= DIR_LEFT;
            r_line_lost      <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_follower_state <= w_follower_nxt;
            r_last_dir       <= w_last_dir_nxt;
            r_line_lost      <= (w_state_nxt == ST_STOPPED);
        end
    end

    // Lost counter restarts on SEARCH entry and saturates at the timeout value
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SEARCH)) begin
            r_lost_cnt <= '0;
        end else if (r_lost_cnt != LOST_W'(LOST_TIMEOUT - 1)) begin
            r_lost_cnt <= r_lost_cnt + 1'b1;
        end
    end

    // Free-running ramp prescaler, one tick every RAMP_DIV cycles
    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Per-state wheel speed targets and the prescaler tick
    always_comb begin
        w_tick     = (r_prescale == RAMP_W'(RAMP_DIV - 1));
        w_target_l = 8'd0;
        w_target_r = 8'd0;
        case (r_state)
            ST_FORWARD: begin
                w_target_l = SPD_MAX;
                w_target_r = SPD_MAX;
            end
            ST_TURN_LEFT: begin
                w_target_l = SPD_TURN;
                w_target_r = SPD_MAX;
            end
            ST_TURN_RIGHT: begin
                w_target_l = SPD_MAX;
                w_target_r = SPD_TURN;
            end
            ST_SEARCH: begin
                w_target_l = SPD_TURN;
                w_target_r = SPD_TURN;
            end
            default: begin
                w_target_l = 8'd0;
                w_target_r = 8'd0;
            end
        endcase
    end

    // Speed ramp: one step toward target per tick; dropping enable stops at once
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            r_speed_l <= 8'd0;
            r_speed_r <= 8'd0;
        end else if (w_tick) begin
            if (r_speed_l < w_target_l) begin
                r_speed_l <= r_speed_l + 8'd1;
            end else if (r_speed_l > w_target_l) begin
                r_speed_l <= r_speed_l - 8'd1;
            end
            if (r_speed_r < w_target_r) begin
                r_speed_r <= r_speed_r + 8'd1;
            end else if (r_speed_r > w_target_r) begin
                r_speed_r <= r_speed_r - 8'd1;
            end
        end
    end

    assign bus.follower_state = r_follower_state;
    assign bus.Wheel_Speed_L  = r_speed_l;
    assign bus.Wheel_Speed_R  = r_speed_r;
    assign bus.line_lost      = r_line_lost;

endmodule
